mips_mc_core: RTL and testbench

- Parametrised successor to the fixed-timing multicycle MIPS core.
- Same five-step instruction flow (fetch, decode, execute, memory, writeback), now driven by an explicit FSM.
- Both memories use req/ack handshakes, so any number of wait states is tolerated.
- Wider instruction set: adds branches, J, SUBU/AND/OR/SLT/ORI/LUI. JAL now links correctly.
- Sits between the instruction/data memory models and the testbench. Contains its own register file.

---
 rtl/mips_mc_pkg.sv | 107 ++++++++++
 rtl/mips_mc_if.sv | 26 ++
 rtl/mips_mc_regfile.sv | 36 +++
 rtl/mips_mc_core.sv | 129 ++++++++++++
 tb/tb_mips_mc_core.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mc_pkg.sv
// Shared types for the multicycle MIPS core: encodings, ALU ops, FSM states, decode.
// S_HALT only exists when MIPS_MC_ILLEGAL_TRAP_EN is defined.
`timescale 1ns/1ps
package mips_mc_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDIU = 6'h09,
    OP_ORI   = 6'h0D,
    OP_LUI   = 6'h0F,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00,
    FN_JR   = 6'h08,
    FN_ADDU = 6'h21,
    FN_SUBU = 6'h23,
    FN_AND  = 6'h24,
    FN_OR   = 6'h25,
    FN_SLT  = 6'h2A
  } funct_e;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_LUI} alu_op_e;

  typedef enum logic [2:0] {
    S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
    , S_HALT
`endif
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_SP   = 5'd29;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef struct packed {
    logic    legal;
    alu_op_e alu_op;
    logic    writes;
    logic [4:0] dest;
    logic    use_imm;
    logic    zext;
    logic    is_lw;
    logic    is_sw;
    logic    is_beq;
    logic    is_bne;
    logic    is_j;
    logic    is_jal;
    logic    is_jr;
  } ctrl_t;

  function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SLT: return {31'b0, $signed(a) < $signed(b)};
      ALU_LUI: return {b[15:0], 16'h0000};
      default: return a + b;
    endcase
  endfunction

  // Unsupported encodings leave every control bit clear, i.e. they behave as NOP.
  function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] funct,
                                   input logic [4:0] rt, input logic [4:0] rd);
    ctrl_t c;
    c = '0;
    c.alu_op = ALU_ADD;
    c.dest   = rd;
    case (op)
      OP_RTYPE: begin
        c.legal  = 1'b1;
        c.writes = 1'b1;
        case (funct)
          FN_SLL:  c.writes = 1'b0;
          FN_JR:   begin c.writes = 1'b0; c.is_jr = 1'b1; end
          FN_ADDU: c.alu_op = ALU_ADD;
          FN_SUBU: c.alu_op = ALU_SUB;
          FN_AND:  c.alu_op = ALU_AND;
          FN_OR:   c.alu_op = ALU_OR;
          FN_SLT:  c.alu_op = ALU_SLT;
          default: begin c.legal = 1'b0; c.writes = 1'b0; end
        endcase
      end
      OP_J:     begin c.legal = 1'b1; c.is_j = 1'b1; end
      OP_JAL:   begin c.legal = 1'b1; c.is_j = 1'b1; c.is_jal = 1'b1; c.writes = 1'b1; c.dest = REG_RA; end
      OP_BEQ:   begin c.legal = 1'b1; c.is_beq = 1'b1; end
      OP_BNE:   begin c.legal = 1'b1; c.is_bne = 1'b1; end
      OP_ADDIU: begin c.legal = 1'b1; c.writes = 1'b1; c.dest = rt; c.use_imm = 1'b1; end
      OP_ORI:   begin c.legal = 1'b1; c.writes = 1'b1; c.dest = rt; c.use_imm = 1'b1;
                      c.zext = 1'b1; c.alu_op = ALU_OR; end
      OP_LUI:   begin c.legal = 1'b1; c.writes = 1'b1; c.dest = rt; c.use_imm = 1'b1; c.alu_op = ALU_LUI; end
      OP_LW:    begin c.legal = 1'b1; c.writes = 1'b1; c.dest = rt; c.use_imm = 1'b1; c.is_lw = 1'b1; end
      OP_SW:    begin c.legal = 1'b1; c.use_imm = 1'b1; c.is_sw = 1'b1; end
      default:  c.legal = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_mc_if.sv
// Instruction and data memory buses of the multicycle core.
// Handshake: req (with addr/we/wdata) stays high and stable until the cycle ack is sampled high;
// ack may arrive in the same cycle req rises; ack while req is low means nothing.
`timescale 1ns/1ps
interface mips_mc_if #(parameter int ADDR_W = 32);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              imem_ack;
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic [31:0]       dmem_rdata;
  logic              dmem_ack;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_rdata, imem_ack, dmem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_rdata, imem_ack, dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mips_mc_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port.
// Reset preloads the stack pointer and return address; r0 is hardwired to zero.
`timescale 1ns/1ps
module mips_mc_regfile
  import mips_mc_pkg::*;
#(
  parameter logic [31:0] SP_INIT = 32'h0,
  parameter logic [31:0] RA_INIT = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_addr,
  output logic [31:0] rs_data,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rt_data,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs [32];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
      regs[REG_SP] <= SP_INIT;
      regs[REG_RA] <= RA_INIT;
    end else if (we && (waddr != REG_ZERO)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rs_data = (rs_addr == REG_ZERO) ? 32'h0 : regs[rs_addr];
  assign rt_data = (rt_addr == REG_ZERO) ? 32'h0 : regs[rt_addr];

endmodule

// File: rtl/mips_mc_core.sv
// Multicycle MIPS core (fetch/decode/execute/memory/writeback) with req/ack memory buses.
// Define MIPS_MC_ILLEGAL_TRAP_EN to halt on unsupported encodings instead of treating them as NOP.
`timescale 1ns/1ps
module mips_mc_core
  import mips_mc_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0,
  parameter logic [31:0] SP_INIT = 32'h0,
  parameter logic [31:0] RA_INIT = 32'h0,
  parameter int          ADDR_W  = 32
) (
  input  logic      clk,
  input  logic      reset,
  mips_mc_if.master bus,
  output logic      retire,
  output logic      illegal,
  output state_e    dbg_state
);

  state_e      state, state_nxt;
  logic [31:0] pc, ir, a_q, b_q, imm_q, res_q;
  logic [31:0] rs_data, rt_data, imm_ext, alu_out, pc4, pc_nxt;
  logic        taken;
  ctrl_t       ctrl;

  assign ctrl    = decode(ir[31:26], ir[5:0], ir[20:16], ir[15:11]);
  assign imm_ext = ctrl.zext ? {16'h0000, ir[15:0]} : {{16{ir[15]}}, ir[15:0]};

  mips_mc_regfile #(.SP_INIT(SP_INIT), .RA_INIT(RA_INIT)) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .rs_addr (ir[25:21]),
    .rs_data (rs_data),
    .rt_addr (ir[20:16]),
    .rt_data (rt_data),
    .we      ((state == S_WB) && ctrl.writes),
    .waddr   (ctrl.dest),
    .wdata   (res_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_BOOT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_BOOT:   state_nxt = S_FETCH;
      S_FETCH:  if (bus.imem_ack) state_nxt = S_DECODE;
      S_DECODE: begin
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
        state_nxt = ctrl.legal ? S_EXEC : S_HALT;
`else
        state_nxt = S_EXEC;
`endif
      end
      S_EXEC:   state_nxt = (ctrl.is_lw || ctrl.is_sw) ? S_MEM : S_WB;
      S_MEM:    if (bus.dmem_ack) state_nxt = S_WB;
      S_WB:     state_nxt = S_FETCH;
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
      S_HALT:   state_nxt = S_HALT;
`endif
      default:  state_nxt = S_BOOT;
    endcase
  end

  assign alu_out = alu(ctrl.alu_op, a_q, ctrl.use_imm ? imm_q : b_q);
  assign pc4     = pc + 32'd4;
  assign taken   = (ctrl.is_beq && (a_q == b_q)) || (ctrl.is_bne && (a_q != b_q));

  always_comb begin
    pc_nxt = pc4;
    if (taken)            pc_nxt = pc4 + {imm_q[29:0], 2'b00};
    else if (ctrl.is_j)   pc_nxt = {pc4[31:28], ir[25:0], 2'b00};
    else if (ctrl.is_jr)  pc_nxt = {a_q[31:2], 2'b00};
  end

  // res_q carries the ALU result, the link address, the memory address and finally load data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc    <= PC_INIT;
      ir    <= 32'h0;
      a_q   <= 32'h0;
      b_q   <= 32'h0;
      imm_q <= 32'h0;
      res_q <= 32'h0;
    end else begin
      case (state)
        S_FETCH:  if (bus.imem_ack) ir <= bus.imem_rdata;
        S_DECODE: begin
          a_q   <= rs_data;
          b_q   <= rt_data;
          imm_q <= imm_ext;
        end
        S_EXEC: begin
          res_q <= ctrl.is_jal ? pc4 : alu_out;
          pc    <= pc_nxt;
        end
        S_MEM:    if (bus.dmem_ack && ctrl.is_lw) res_q <= bus.dmem_rdata;
        default:  ;
      endcase
    end
  end

`ifdef MIPS_MC_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                illegal_q <= 1'b0;
    else if (state == S_DECODE && !ctrl.legal) illegal_q <= 1'b1;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign bus.imem_req   = (state == S_FETCH);
  assign bus.imem_addr  = bus.imem_req ? pc[ADDR_W-1:0] : '0;
  assign bus.dmem_req   = (state == S_MEM);
  assign bus.dmem_we    = bus.dmem_req && ctrl.is_sw;
  assign bus.dmem_addr  = bus.dmem_req ? res_q[ADDR_W-1:0] : '0;
  assign bus.dmem_wdata = bus.dmem_req ? b_q : 32'h0;
  assign retire         = (state == S_WB);
  assign dbg_state      = state;

  logic unused_bits;
  assign unused_bits = ^{ir[10:6], imm_q[31:30], ctrl.legal, pc};

endmodule

// File: tb/tb_mips_mc_core.sv
// Directed bench for mips_mc_core: program walk with fetch-order/latency scoreboard, memory handshake and reset checks.
`timescale 1ns/1ps
module tb_mips_mc_core;
  import mips_mc_pkg::*;

  localparam logic [31:0] PC_INIT = 32'h0000_0100;
  localparam logic [31:0] SP_INIT = 32'h0000_1000;
  localparam logic [31:0] RA_INIT = 32'h0000_0ABC;

  logic   clk = 1'b0;
  logic   reset = 1'b0;
  logic   retire, illegal;
  state_e dbg_state;

  mips_mc_if #(.ADDR_W(32)) bus ();

  mips_mc_core #(.PC_INIT(PC_INIT), .SP_INIT(SP_INIT), .RA_INIT(RA_INIT), .ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .retire    (retire),
    .illegal   (illegal),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory models ----------------
  logic [31:0] imem [0:1023];
  logic [31:0] dmem [0:255];
  int iwaits = 0, dwaits = 3, icnt = 0, dcnt = 0;

  assign bus.imem_rdata = imem[bus.imem_addr[11:2]];
  assign bus.imem_ack   = bus.imem_req && (icnt >= iwaits);
  assign bus.dmem_rdata = dmem[bus.dmem_addr[9:2]];
  assign bus.dmem_ack   = bus.dmem_req && (dcnt >= dwaits);

  always @(posedge clk) begin
    icnt <= (bus.imem_req && !bus.imem_ack) ? icnt + 1 : 0;
    dcnt <= (bus.dmem_req && !bus.dmem_ack) ? dcnt + 1 : 0;
    if (bus.dmem_req && bus.dmem_ack && bus.dmem_we) dmem[bus.dmem_addr[9:2]] <= bus.dmem_wdata;
  end

  int last_retire_cyc = -1, retire_cnt = 0;
  always @(negedge clk) if (retire) begin
    last_retire_cyc <= cyc;
    retire_cnt      <= retire_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          mem_q[$];
  int n_vec = 0, n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic expect_next(input logic [31:0] addr, input int lat, input int mem_kind);
    exp_q.push_back(addr);
    lat_q.push_back(lat);
    mem_q.push_back(mem_kind);
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_fetch(output int fcyc, output logic [31:0] faddr);
    fcyc  = -1;
    faddr = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.imem_req && bus.imem_ack) begin
        fcyc  = cyc;
        faddr = bus.imem_addr;
        break;
      end
    end
  endtask

  task automatic check_mem(input string tag, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check_eq({tag, "_req"},   32'(bus.dmem_req), 32'd1);
      check_eq({tag, "_we"},    32'(bus.dmem_we),  32'(we));
      check_eq({tag, "_addr"},  bus.dmem_addr,     addr);
      check_eq({tag, "_wdata"}, bus.dmem_wdata,    wdata);
      @(negedge clk);
    end
    check_eq({tag, "_req_drop"}, 32'(bus.dmem_req), 32'd0);
  endtask

  task automatic check_regs();
    check_eq("r0",  dut.u_regfile.regs[0],  32'h0000_0000);
    check_eq("r1",  dut.u_regfile.regs[1],  32'hFFFF_FFFF);
    check_eq("r2",  dut.u_regfile.regs[2],  32'hFFFF_FFFE);
    check_eq("r3",  dut.u_regfile.regs[3],  32'hFFFF_FFFE);
    check_eq("r5",  dut.u_regfile.regs[5],  32'h0000_0000);
    check_eq("r6",  dut.u_regfile.regs[6],  32'h8000_0000);
    check_eq("r7",  dut.u_regfile.regs[7],  32'h0000_FFFF);
    check_eq("r8",  dut.u_regfile.regs[8],  32'hFFFF_0001);
    check_eq("r9",  dut.u_regfile.regs[9],  32'h0000_0001);
    check_eq("r10", dut.u_regfile.regs[10], 32'h0000_0001);
    check_eq("r11", dut.u_regfile.regs[11], 32'h8000_FFFF);
    check_eq("r29", dut.u_regfile.regs[29], SP_INIT);
    check_eq("r31", dut.u_regfile.regs[31], 32'h0000_0304);
    check_eq("dmem_word", dmem[2], 32'hFFFF_FFFE);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          fcyc, prev, rel_cyc, kind, lat, req_seen;
    logic [31:0] faddr, eaddr;

    for (int i = 0; i < 1024; i++) imem[i] = 32'h0;
    for (int i = 0; i < 256; i++)  dmem[i] = 32'h0;
    imem[32'h100 >> 2] = 32'h2401FFFF;  // addiu r1,r0,-1
    imem[32'h104 >> 2] = 32'h00211021;  // addu  r2,r1,r1
    imem[32'h108 >> 2] = 32'hAFA20008;  // sw    r2,8(r29)
    imem[32'h10C >> 2] = 32'h8FA30008;  // lw    r3,8(r29)
    imem[32'h110 >> 2] = 32'h08000080;  // j     0x200
    imem[32'h200 >> 2] = 32'h10000002;  // beq   r0,r0,+2
    imem[32'h204 >> 2] = 32'h24050055;  // skipped
    imem[32'h208 >> 2] = 32'h24050066;  // skipped
    imem[32'h20C >> 2] = 32'h14000005;  // bne   r0,r0,+5
    imem[32'h210 >> 2] = 32'h080000C0;  // j     0x300
    imem[32'h300 >> 2] = 32'h0C000010;  // jal   0x40
    imem[32'h040 >> 2] = 32'h03E00008;  // jr    r31
    imem[32'h304 >> 2] = 32'h3C068000;  // lui   r6,0x8000
    imem[32'h308 >> 2] = 32'h3407FFFF;  // ori   r7,r0,0xffff
    imem[32'h30C >> 2] = 32'h00074023;  // subu  r8,r0,r7
    imem[32'h310 >> 2] = 32'h00C7482A;  // slt   r9,r6,r7
    imem[32'h314 >> 2] = 32'h01075024;  // and   r10,r8,r7
    imem[32'h318 >> 2] = 32'h00C75825;  // or    r11,r6,r7
    imem[32'h31C >> 2] = 32'h24200005;  // addiu r0,r1,5
    imem[32'h320 >> 2] = 32'h00000140;  // nop with shamt
    imem[32'h324 >> 2] = 32'hFC000000;  // unsupported opcode
    imem[32'h328 >> 2] = 32'h080000CA;  // j     0x328

    expect_next(32'h104, 4, 0);
    expect_next(32'h108, 4, 0);
    expect_next(32'h10C, 8, 1);
    expect_next(32'h110, 8, 2);
    expect_next(32'h200, 4, 0);
    expect_next(32'h20C, 4, 0);
    expect_next(32'h210, 4, 0);
    expect_next(32'h300, 4, 0);
    expect_next(32'h040, 4, 0);
    expect_next(32'h304, 4, 0);
    expect_next(32'h308, 4, 0);
    expect_next(32'h30C, 4, 0);
    expect_next(32'h310, 4, 0);
    expect_next(32'h314, 4, 0);
    expect_next(32'h318, 4, 0);
    expect_next(32'h31C, 4, 0);
    expect_next(32'h320, 4, 0);
    expect_next(32'h324, 4, 0);
`ifndef MIPS_MC_ILLEGAL_TRAP_EN
    expect_next(32'h328, 4, 0);
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_imem_req",  32'(bus.imem_req),  32'd0);
    check_eq("rst_imem_addr", bus.imem_addr,      32'h0);
    check_eq("rst_dmem_req",  32'(bus.dmem_req),  32'd0);
    check_eq("rst_dmem_wdata", bus.dmem_wdata,    32'h0);
    check_eq("rst_retire",    32'(retire),        32'd0);
    check_eq("rst_illegal",   32'(illegal),       32'd0);
    check_eq("rst_state",     32'(dbg_state),     32'(S_BOOT));
    check_eq("rst_pc",        dut.pc,             PC_INIT);
    check_eq("rst_r29",       dut.u_regfile.regs[29], SP_INIT);
    check_eq("rst_r31",       dut.u_regfile.regs[31], RA_INIT);

    reset   = 1'b1;
    rel_cyc = cyc;
    wait_fetch(fcyc, faddr);
    check_eq("boot_fetch_addr", faddr, PC_INIT);
    check_eq("boot_fetch_lat",  fcyc - rel_cyc, 32'd1);
    prev = fcyc;

    while (exp_q.size() > 0) begin
      eaddr = exp_q.pop_front();
      lat   = lat_q.pop_front();
      kind  = mem_q.pop_front();
      if (kind == 1)      check_mem("sw", 1'b1, SP_INIT + 32'd8, 32'hFFFF_FFFE);
      else if (kind == 2) check_mem("lw", 1'b0, SP_INIT + 32'd8, 32'h0);
      wait_fetch(fcyc, faddr);
      check_eq("fetch_seen", 32'(fcyc >= 0), 32'd1);
      check_eq("fetch_addr", faddr, eaddr);
      check_eq("fetch_lat",  fcyc - prev, lat);
      check_eq("retire_before_fetch", last_retire_cyc, fcyc - 1);
      prev = fcyc;
    end

`ifdef MIPS_MC_ILLEGAL_TRAP_EN
    req_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.imem_req) req_seen++;
    end
    check_eq("halt_no_req",  req_seen, 32'd0);
    check_eq("halt_illegal", 32'(illegal), 32'd1);
    check_eq("halt_state",   32'(dbg_state), 32'(S_HALT));
    check_eq("halt_pc",      dut.pc, 32'h0000_0324);
    check_eq("retire_count", retire_cnt, 32'd18);
    check_regs();
    reset = 1'b0;
    #1;
    check_eq("halt_reset_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    rel_cyc = cyc;
    wait_fetch(fcyc, faddr);
    check_eq("rerun_fetch_addr", faddr, PC_INIT);
    check_eq("rerun_fetch_lat",  fcyc - rel_cyc, 32'd1);
`else
    check_eq("nop_illegal",  32'(illegal), 32'd0);
    check_eq("retire_count", retire_cnt, 32'd19);
    check_regs();
    // stretch the next fetch, then pull reset in the middle of it
    @(negedge clk);
    iwaits   = 10;
    req_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.imem_req) begin
        req_seen = 1;
        break;
      end
    end
    check_eq("stall_req_seen", req_seen, 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("midrst_imem_req",  32'(bus.imem_req), 32'd0);
    check_eq("midrst_imem_addr", bus.imem_addr, 32'h0);
    check_eq("midrst_state",     32'(dbg_state), 32'(S_BOOT));
    check_eq("midrst_pc",        dut.pc, PC_INIT);
    check_eq("midrst_r31",       dut.u_regfile.regs[31], RA_INIT);
    check_eq("midrst_r1",        dut.u_regfile.regs[1], 32'h0);
    iwaits = 0;
    @(negedge clk);
    reset = 1'b1;
    rel_cyc = cyc;
    wait_fetch(fcyc, faddr);
    check_eq("rerun_fetch_addr", faddr, PC_INIT);
    check_eq("rerun_fetch_lat",  fcyc - rel_cyc, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
